dmem_access_unit: RTL

//  Data-memory responder for the core's DMEM control (mem_read/mem_write, d_size, d_unsigned).

---
 rtl/dmem_access_unit.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - data-memory load/store sequencer producing word-aligned req/gnt/rvalid bus beats
//
// Purpose:
//   Accepts one load or store from the MEM stage, issues one (or, when
//   DMEM_MISALIGNED_SPLIT_EN is defined, two) word-aligned bus beats with byte
//   enables, extends returned load data and pulses o_done when finished.
//   Without DMEM_MISALIGNED_SPLIT_EN a lane-crossing access is rejected with
//   o_misaligned and never reaches the bus.
//
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_mem_read, i_mem_write        request (held until o_done; write wins)
//   i_d_size, i_d_unsigned         00 byte / 01 half / 1x word, zero-extend load
//   i_addr, i_wdata                byte address, LSB-aligned store data
//   o_stall, o_done, o_rdata       pipeline stall, completion pulse, load data
//   o_misaligned                   crossing access rejected (pulses with o_done)
//   o_bus_req/we/addr/be/wdata     beat request towards memory/fabric
//   i_bus_gnt, i_bus_rvalid/rdata  beat accept and beat response
module dmem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [1:0]        i_d_size,
  input  logic              i_d_unsigned,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_stall,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_misaligned,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [3:0]        o_bus_be,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_gnt,
  input  logic              i_bus_rvalid,
  input  logic [DATA_W-1:0] i_bus_rdata
);

  typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} state_t;

  state_t            state;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              uns_q;

  // Lane geometry of the incoming request: an 8-lane window covering two words.
  logic [1:0]        off;
  logic [3:0]        mask;
  logic [7:0]        lanes;
  logic              crossing;
  logic [ADDR_W-1:0] beat0_addr;
  logic [DATA_W-1:0] beat0_wdata;

  always_comb begin
    off = i_addr[1:0];
    case (i_d_size)
      2'b00:   mask = 4'h1;
      2'b01:   mask = 4'h3;
      default: mask = 4'hF;
    endcase
    lanes    = {4'h0, mask} << off;
    crossing = |lanes[7:4];
  end

  assign beat0_addr  = {i_addr[ADDR_W-1:2], 2'b00};
  assign beat0_wdata = i_wdata << {off, 3'b000};

`ifdef DMEM_MISALIGNED_SPLIT_EN
  logic              split_q;
  logic [ADDR_W-1:0] b1_addr_q;
  logic [3:0]        b1_be_q;
  logic [DATA_W-1:0] b1_wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] beat1_wdata;

  // The bytes that spilled past lane 3 land at the bottom of the next word.
  assign beat1_wdata = i_wdata >> (6'd32 - {1'b0, off, 3'b000});
`endif

  // Load extraction: the two response words form a 64-bit window shifted down
  // by the byte offset; the final word arrives on i_bus_rdata in this cycle.
  logic [DATA_W-1:0] lo_word;
  logic [DATA_W-1:0] hi_word;
  logic [DATA_W-1:0] ld_shift;
  logic [DATA_W-1:0] ld_ext;

  always_comb begin
`ifdef DMEM_MISALIGNED_SPLIT_EN
    lo_word = (state == RSP0) ? i_bus_rdata : rdata0_q;
    hi_word = (state == RSP1) ? i_bus_rdata : 32'h0;
`else
    lo_word = i_bus_rdata;
    hi_word = 32'h0;
`endif
    ld_shift = 32'({hi_word, lo_word} >> {off_q, 3'b000});
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'h0, ld_shift[7:0]}  : {{24{ld_shift[7]}},  ld_shift[7:0]};
      2'b01:   ld_ext = uns_q ? {16'h0, ld_shift[15:0]} : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  assign o_stall = (i_mem_read | i_mem_write) & ~o_done;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      o_done       <= 1'b0;
      o_rdata      <= '0;
      o_misaligned <= 1'b0;
      o_bus_req    <= 1'b0;
      o_bus_we     <= 1'b0;
      o_bus_addr   <= '0;
      o_bus_be     <= 4'h0;
      o_bus_wdata  <= '0;
`ifdef DMEM_MISALIGNED_SPLIT_EN
      split_q      <= 1'b0;
      b1_addr_q    <= '0;
      b1_be_q      <= 4'h0;
      b1_wdata_q   <= '0;
      rdata0_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_mem_read | i_mem_write) begin
            off_q  <= off;
            size_q <= i_d_size;
            uns_q  <= i_d_unsigned;
`ifdef DMEM_MISALIGNED_SPLIT_EN
            split_q     <= crossing;
            b1_addr_q   <= beat0_addr + ADDR_W'(4);
            b1_be_q     <= lanes[7:4];
            b1_wdata_q  <= beat1_wdata;
            o_bus_req   <= 1'b1;
            o_bus_we    <= i_mem_write;
            o_bus_addr  <= beat0_addr;
            o_bus_be    <= lanes[3:0];
            o_bus_wdata <= beat0_wdata;
            state       <= REQ0;
`else
            if (crossing) begin
              // Rejected before touching the bus.
              o_done       <= 1'b1;
              o_misaligned <= 1'b1;
              o_rdata      <= '0;
              state        <= DONE;
            end else begin
              o_bus_req   <= 1'b1;
              o_bus_we    <= i_mem_write;
              o_bus_addr  <= beat0_addr;
              o_bus_be    <= lanes[3:0];
              o_bus_wdata <= beat0_wdata;
              state       <= REQ0;
            end
`endif
          end
        end
        REQ0: begin
          if (i_bus_gnt) begin
            o_bus_req <= 1'b0;
            state     <= RSP0;
          end
        end
        RSP0: begin
          if (i_bus_rvalid) begin
`ifdef DMEM_MISALIGNED_SPLIT_EN
            if (split_q) begin
              rdata0_q    <= i_bus_rdata;
              o_bus_req   <= 1'b1;
              o_bus_addr  <= b1_addr_q;
              o_bus_be    <= b1_be_q;
              o_bus_wdata <= b1_wdata_q;
              state       <= REQ1;
            end else begin
              o_done  <= 1'b1;
              o_rdata <= o_bus_we ? '0 : ld_ext;
              state   <= DONE;
            end
`else
            o_done  <= 1'b1;
            o_rdata <= o_bus_we ? '0 : ld_ext;
            state   <= DONE;
`endif
          end
        end
`ifdef DMEM_MISALIGNED_SPLIT_EN
        REQ1: begin
          if (i_bus_gnt) begin
            o_bus_req <= 1'b0;
            state     <= RSP1;
          end
        end
        RSP1: begin
          if (i_bus_rvalid) begin
            o_done  <= 1'b1;
            o_rdata <= o_bus_we ? '0 : ld_ext;
            state   <= DONE;
          end
        end
`endif
        DONE: begin
          // Request inputs are still high here; they are deliberately ignored.
          o_done       <= 1'b0;
          o_misaligned <= 1'b0;
          o_rdata      <= '0;
          o_bus_we     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
